// File: rtl/int_arbiter_if.sv
// Register-port bundle between software (master) and the interrupt arbiter (slave).
// Single-cycle strobes; read data returns registered one cycle after re_i.
interface int_arbiter_if;
  logic        re_i;
  logic        we_i;
  logic [7:0]  addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (
    output re_i,
    output we_i,
    output addr_i,
    output data_i,
    input  data_o
  );

  modport slave (
    input  re_i,
    input  we_i,
    input  addr_i,
    input  data_i,
    output data_o
  );
endinterface

// File: rtl/int_arbiter.sv
// Fixed-priority interrupt arbiter: sync + edge-detect lines, latch pending, raise one request.
// Edge->pending 3 cycles, pending->int_flag 2 cycles; no new request until claim/complete.
module int_arbiter #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 5
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_SRC-1:0] irq_i,
  int_arbiter_if.slave       bus,
  output logic [7:0]         int_flag_o,
  output logic [ID_W-1:0]    claim_id_o
);

  localparam logic [5:0] A_PENDING = 6'd0;
  localparam logic [5:0] A_ENABLE  = 6'd1;
  localparam logic [5:0] A_CLAIM   = 6'd2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b001,
    S_ASSERT  = 3'b010,
    S_SERVICE = 3'b100
  } state_t;

  state_t             state, state_nxt;
  logic [NUM_SRC-1:0] sync1, sync2, sync3;
  logic [NUM_SRC-1:0] rise, pending, enable, masked, clr_mask;
  logic [ID_W-1:0]    win_id;
  logic [5:0]         word;
  logic               rd_en, wr_en, rd_claim, wr_claim;
  logic               claim, complete, flag_nxt;
  logic [31:0]        rd_data;
  logic               unused_bits;

  assign word   = bus.addr_i[7:2];
  assign rd_en  = bus.re_i;
  // A simultaneous read wins; the write is dropped.
  assign wr_en  = bus.we_i & ~bus.re_i;
  assign rd_claim = rd_en && (word == A_CLAIM);
  assign wr_claim = wr_en && (word == A_CLAIM);
  assign rise   = sync2 & ~sync3;
  assign masked = pending & enable;
  assign unused_bits = ^{bus.addr_i[1:0], bus.data_i};

  always_comb begin
    win_id = '0;
    for (int n = NUM_SRC - 1; n >= 0; n--) begin
      if (masked[n]) win_id = ID_W'(n + 1);
    end
  end

  always_comb begin
    state_nxt = state;
    claim     = 1'b0;
    complete  = 1'b0;
    case (state)
      S_IDLE: begin
        if (rd_claim && win_id != '0) begin
          claim     = 1'b1;
          state_nxt = S_SERVICE;
        end else if (win_id != '0) begin
          state_nxt = S_ASSERT;
        end
      end
      S_ASSERT: begin
        // A vanished winner takes precedence over a claim in the same cycle.
        if (win_id == '0) begin
          state_nxt = S_IDLE;
        end else if (rd_claim) begin
          claim     = 1'b1;
          state_nxt = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (wr_claim && bus.data_i[ID_W-1:0] == claim_id_o) begin
          complete  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Flag rises one cycle after entering S_ASSERT and drops on the leaving edge.
    flag_nxt = (state == S_ASSERT) && (state_nxt == S_ASSERT);
  end

  always_comb begin
    for (int n = 0; n < NUM_SRC; n++) begin
      clr_mask[n] = claim && (win_id == ID_W'(n + 1));
    end
  end

  always_comb begin
    rd_data = '0;
    case (word)
      A_PENDING: rd_data = 32'(pending);
      A_ENABLE:  rd_data = 32'(enable);
      A_CLAIM:   rd_data = (state == S_SERVICE) ? 32'd0 : 32'(win_id);
      default:   rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= irq_i;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // New edges are OR-ed in after the claim clear so a coincident edge survives.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | rise;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      enable <= '0;
    end else if (wr_en && word == A_ENABLE) begin
      enable <= bus.data_i[NUM_SRC-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.data_o <= '0;
    end else if (rd_en) begin
      bus.data_o <= rd_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      int_flag_o <= '0;
      claim_id_o <= '0;
    end else begin
      state      <= state_nxt;
      int_flag_o <= {7'd0, flag_nxt};
      if (claim) begin
        claim_id_o <= win_id;
      end else if (complete) begin
        claim_id_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_int_arbiter.sv
// Directed + random bench for int_arbiter against a cycle-level behavioural model.
module tb_int_arbiter;
  localparam int NS = 8;

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;
  logic [NS-1:0] irq;
  logic [7:0]    flag;
  logic [4:0]    cid;

  int n_cmp = 0;
  int n_bad = 0;

  int_arbiter_if bus ();

  int_arbiter #(.NUM_SRC(NS), .ID_W(5)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .irq_i      (irq),
    .bus        (bus),
    .int_flag_o (flag),
    .claim_id_o (cid)
  );

  always #5 clk = ~clk;

  // Reference model: irq samples delayed by history, pending/enable bit sets,
  // serving ID (0 = none) and how many edges a request has been standing.
  logic [NS-1:0] m_pend, m_en, h1, h2, h3;
  int            m_serv, m_raised;
  logic [31:0]   m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int winner();
    for (int n = 0; n < NS; n++) begin
      if (m_pend[n] && m_en[n]) return n + 1;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_en = '0; h1 = '0; h2 = '0; h3 = '0;
    m_serv = 0; m_raised = 0; m_data = '0;
  endtask

  task automatic model_step();
    int w, a;
    logic [NS-1:0] edges, clr;
    bit do_rd, do_wr;
    w = winner();
    edges = h2 & ~h3;
    h3 = h2; h2 = h1; h1 = irq;
    a = int'(bus.addr_i[7:2]);
    do_rd = bus.re_i;
    do_wr = bus.we_i && !bus.re_i;
    clr = '0;
    if (do_rd) begin
      case (a)
        0: m_data = 32'(m_pend);
        1: m_data = 32'(m_en);
        2: m_data = (m_serv != 0) ? 32'd0 : 32'(w);
        default: m_data = 32'd0;
      endcase
    end
    if (m_serv != 0) begin
      if (do_wr && a == 2 && bus.data_i[4:0] == 5'(m_serv)) m_serv = 0;
    end else if (do_rd && a == 2 && w != 0) begin
      clr[w-1] = 1'b1;
      m_serv = w;
      m_raised = 0;
    end else if (w != 0) begin
      if (m_raised < 2) m_raised++;
    end else begin
      m_raised = 0;
    end
    m_pend = (m_pend & ~clr) | edges;
    if (do_wr && a == 1) m_en = bus.data_i[NS-1:0];
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rstn) model_reset();
    else model_step();
    @(negedge clk);
    chk("int_flag", 32'(flag), (m_raised >= 2) ? 32'd1 : 32'd0);
    chk("claim_id", 32'(cid), 32'(m_serv));
    chk("data_o", bus.data_o, m_data);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic rd(input logic [7:0] a);
    bus.re_i = 1'b1; bus.addr_i = a;
    cyc();
    bus.re_i = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.we_i = 1'b1; bus.addr_i = a; bus.data_i = d;
    cyc();
    bus.we_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    logic [5:0] a6;
    irq = '0;
    bus.re_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.data_i = '0;
    model_reset();

    idle(2);
    chk("rst_data_o", bus.data_o, 32'd0);
    chk("rst_flag", 32'(flag), 32'd0);
    chk("rst_claim", 32'(cid), 32'd0);
    rstn = 1'b1;
    idle(1);

    // Single source, edge to flag to claim.
    wr(8'h04, 32'h1);
    irq[0] = 1'b1;
    idle(3);
    rd(8'h00);
    chk("t1_pending", bus.data_o, 32'h1);
    chk("t1_flag_pre", 32'(flag), 32'd0);
    idle(1);
    chk("t1_flag", 32'(flag), 32'h1);
    irq[0] = 1'b0;
    rd(8'h08);
    chk("t1_claim_rd", bus.data_o, 32'd1);
    chk("t1_flag_off", 32'(flag), 32'd0);
    chk("t1_claim_id", 32'(cid), 32'd1);
    rd(8'h00);
    chk("t1_pend_clr", bus.data_o, 32'd0);
    wr(8'h08, 32'd1);

    // Two simultaneous sources, lowest index first.
    wr(8'h04, 32'hFF);
    irq = irq | 8'h24;
    idle(5);
    rd(8'h08);
    chk("t2_first", bus.data_o, 32'd3);
    wr(8'h08, 32'd3);
    idle(2);
    chk("t2_rearm", 32'(flag), 32'd1);
    rd(8'h08);
    chk("t2_second", bus.data_o, 32'd6);
    wr(8'h08, 32'd6);
    irq = '0;

    // Wrong completion ID is ignored; service claim read returns 0.
    irq[0] = 1'b1;
    idle(5);
    rd(8'h08);
    chk("t3_claim", bus.data_o, 32'd1);
    rd(8'h08);
    chk("t3_svc_rd", bus.data_o, 32'd0);
    wr(8'h08, 32'd2);
    chk("t3_wrong_id", 32'(cid), 32'd1);
    wr(8'h08, 32'd1);
    chk("t3_done", 32'(cid), 32'd0);
    idle(3);
    chk("t3_quiet", 32'(flag), 32'd0);

    // Pending latches while disabled; enable raises, disable drops.
    irq = '0;
    wr(8'h04, 32'h0);
    irq[3] = 1'b1;
    idle(4);
    rd(8'h00);
    chk("t4_pend", bus.data_o, 32'h08);
    chk("t4_noflag", 32'(flag), 32'd0);
    wr(8'h04, 32'h08);
    idle(2);
    chk("t4_en_flag", 32'(flag), 32'd1);
    wr(8'h04, 32'h0);
    idle(2);
    chk("t4_dis_flag", 32'(flag), 32'd0);

    // Edge arriving on the claim cycle survives the claim clear.
    wr(8'h04, 32'h1);
    irq[0] = 1'b1;
    idle(5);
    irq[0] = 1'b0;
    idle(1);
    irq[0] = 1'b1;
    idle(2);
    rd(8'h08);
    chk("t5_claim", bus.data_o, 32'd1);
    rd(8'h00);
    chk("t5_pend0", 32'(bus.data_o[0]), 32'd1);
    wr(8'h08, 32'd1);
    idle(2);
    chk("t5_rearm", 32'(flag), 32'd1);
    rd(8'h08);
    wr(8'h08, 32'd1);

    // Asynchronous reset in service.
    irq[0] = 1'b0;
    idle(2);
    irq[0] = 1'b1;
    idle(5);
    rd(8'h08);
    chk("t6_in_svc", 32'(cid), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    chk("t6_flag", 32'(flag), 32'd0);
    chk("t6_claim", 32'(cid), 32'd0);
    chk("t6_data", bus.data_o, 32'd0);
    chk("t6_pending", 32'(dut.pending), 32'd0);
    idle(2);
    rstn = 1'b1;
    idle(2);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) irq = irq ^ (NS'(1) << $urandom_range(0, NS - 1));
      r = int'($urandom_range(0, 9));
      bus.re_i = (r <= 2) || (r == 9);
      bus.we_i = (r >= 3 && r <= 5) || (r == 9);
      a6 = 6'($urandom_range(0, 4));
      bus.addr_i = {a6, 2'($urandom)};
      if ($urandom_range(0, 1) == 1) bus.data_i = {27'($urandom), 5'(m_serv)};
      else bus.data_i = $urandom;
      cyc();
    end
    bus.re_i = 1'b0;
    bus.we_i = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
